// File: rtl/conv_pkg.sv
// Shared definitions for the convolution coprocessor: readout FSM states,
// config field offsets and the result-length helper. The convolution core
// uses the same config decode.
package conv_pkg;

  // Width of each sizeX/sizeY config field.
  localparam int CONV_ADDR_WIDTH = 5;

  // Bit offsets of the size fields inside the config word.
  localparam int SIZEX_LSB = 0;
  localparam int SIZEY_LSB = CONV_ADDR_WIDTH;

  // Result length is one bit wider than a size field.
  localparam int LEN_WIDTH = CONV_ADDR_WIDTH + 1;

  localparam logic [LEN_WIDTH-1:0] LEN_ONE = LEN_WIDTH'(1);

  // Readout FSM states.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_LO   = 3'd2,
    ST_HI   = 3'd3,
    ST_DONE = 3'd4
  } rd_state_e;

  // Full linear convolution length: sizeX + sizeY - 1.
  // The widened sum cannot overflow because each size is at most 2^A-1.
  // The caller must handle a zero-sized operand separately. In that case the
  // result is meaningless.
  function automatic logic [LEN_WIDTH-1:0] conv_len(
    input logic [CONV_ADDR_WIDTH-1:0] size_x,
    input logic [CONV_ADDR_WIDTH-1:0] size_y
  );
    logic [LEN_WIDTH-1:0] sum;
    sum = {1'b0, size_x} + {1'b0, size_y};
    return sum - LEN_ONE;
  endfunction

  // True when either operand is empty, which makes the readout empty.
  function automatic logic conv_empty(
    input logic [CONV_ADDR_WIDTH-1:0] size_x,
    input logic [CONV_ADDR_WIDTH-1:0] size_y
  );
    return (size_x == '0) || (size_y == '0);
  endfunction

endpackage

// File: rtl/conv_result_reader.sv
// Readout engine for the convolution result memory (memZ).
// It walks memZ from address 0 to N-1, where N = sizeX+sizeY-1. Each
// 2*DATA_WIDTH entry is streamed to the host as two DATA_WIDTH words, with
// the low half first.
//
// Output handshake: a word transfers on a rising edge where
// out_valid && out_ready. Once out_valid rises, out_data, out_last and
// memZ_addr stay constant until that transfer happens. out_valid never
// depends on out_ready.
//
// memZ has a registered read, so dataZ follows memZ_addr by one cycle. The
// address is held from LOAD through HI. Because of this, dataZ is stable
// while both halves are presented, and no local data register is needed.
module conv_result_reader
  import conv_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = CONV_ADDR_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [DATA_WIDTH-1:0]   config_in,
  output logic [ADDR_WIDTH:0]     memZ_addr,
  input  logic [2*DATA_WIDTH-1:0] dataZ,
  output logic [DATA_WIDTH-1:0]   out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_last,
  output logic                    busy_out,
  output logic                    done_out,
  output logic [2:0]              dbg_state_o
);

  rd_state_e             state_q, state_d;
  logic [ADDR_WIDTH:0]   idx_q, idx_d;
  logic [ADDR_WIDTH:0]   last_idx_q, last_idx_d;

  logic [ADDR_WIDTH-1:0] cfg_size_x;
  logic [ADDR_WIDTH-1:0] cfg_size_y;
  logic                  cfg_empty;
  logic [ADDR_WIDTH:0]   cfg_len;
  logic                  at_last;
  logic                  unused_cfg;

  // Decode the size fields from the config word presented with start.
  assign cfg_size_x = config_in[SIZEX_LSB +: ADDR_WIDTH];
  assign cfg_size_y = config_in[SIZEY_LSB +: ADDR_WIDTH];
  assign cfg_empty  = conv_empty(cfg_size_x, cfg_size_y);
  assign cfg_len    = conv_len(cfg_size_x, cfg_size_y);

  // The upper config bits belong to other consumers of the config word.
  assign unused_cfg = ^config_in[DATA_WIDTH-1:2*ADDR_WIDTH];

  assign at_last = (idx_q == last_idx_q);

  // The index itself is the memZ read address, so the address is registered.
  assign memZ_addr   = idx_q;
  assign dbg_state_o = state_q;

  // Next state, index update and state-decoded outputs.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    last_idx_d = last_idx_q;
    out_valid  = 1'b0;
    out_data   = '0;
    out_last   = 1'b0;
    busy_out   = 1'b0;
    done_out   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          // The last index is computed once here. After this, the
          // per-element check is only an equality compare.
          last_idx_d = cfg_len - LEN_ONE;
          idx_d      = '0;
          state_d    = cfg_empty ? ST_DONE : ST_LOAD;
        end
      end

      ST_LOAD: begin
        // Wait one cycle for the registered memZ read of idx_q.
        busy_out = 1'b1;
        state_d  = ST_LO;
      end

      ST_LO: begin
        busy_out  = 1'b1;
        out_valid = 1'b1;
        out_data  = dataZ[DATA_WIDTH-1:0];
        if (out_ready) begin
          state_d = ST_HI;
        end
      end

      ST_HI: begin
        busy_out  = 1'b1;
        out_valid = 1'b1;
        out_data  = dataZ[2*DATA_WIDTH-1:DATA_WIDTH];
        out_last  = at_last;
        if (out_ready) begin
          if (at_last) begin
            state_d = ST_DONE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = ST_LOAD;
          end
        end
      end

      ST_DONE: begin
        done_out = 1'b1;
        state_d  = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, index and latched length registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      last_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      last_idx_q <= last_idx_d;
    end
  end

endmodule

// File: tb/tb_conv_result_reader.sv
// Directed bench for conv_result_reader with a registered-read memZ model.
module tb_conv_result_reader;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk;
  logic          rst;
  logic          start;
  logic [DW-1:0] config_in;
  logic [AW:0]   memZ_addr;
  logic [2*DW-1:0] dataZ;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;
  logic          busy_out;
  logic          done_out;
  logic [2:0]    dbg_state;

  logic [2*DW-1:0] mem [0:63];

  int tests_run;
  int tests_failed;

  // Results recorded by run_readout
  logic [DW-1:0] got_q[$];
  logic          got_last_q[$];
  logic [DW-1:0] stall_data_q[$];
  logic [AW:0]   stall_addr_q[$];
  logic          stall_valid_q[$];
  logic          stall_last_q[$];
  int            done_cyc;
  int            done_cnt;
  bit            valid_seen;
  bit            busy_seen;
  logic [DW-1:0] prst_data;
  logic [AW:0]   prst_addr;
  logic [3:0]    prst_flags;  // {valid, last, busy, done}

  conv_result_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .config_in   (config_in),
    .memZ_addr   (memZ_addr),
    .dataZ       (dataZ),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_last    (out_last),
    .busy_out    (busy_out),
    .done_out    (done_out),
    .dbg_state_o (dbg_state)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // memZ model with a registered read
  always @(posedge clk) dataZ <= mem[memZ_addr];

  function automatic logic [DW-1:0] exp_word(input int n);
    if (n % 2 == 0) return 32'(n / 2);
    return 32'hA000_0000 + 32'(n / 2);
  endfunction

  function automatic logic [DW-1:0] make_cfg(input int sx, input int sy);
    logic [DW-1:0] c;
    c = '0;
    c[AW-1:0]    = AW'(sx);
    c[2*AW-1:AW] = AW'(sy);
    return c;
  endfunction

  // Runs one readout. Cycle c has start sampled at c==0. Inputs are driven
  // right after the edge, and outputs are sampled at the negedge.
  task automatic run_readout(input int sx, input int sy, input int stall_at,
                             input int stall_len, input int restart_at,
                             input int rst_at, input int max_cyc);
    got_q.delete(); got_last_q.delete();
    stall_data_q.delete(); stall_addr_q.delete();
    stall_valid_q.delete(); stall_last_q.delete();
    done_cyc = -1; done_cnt = 0; valid_seen = 0; busy_seen = 0;
    prst_data = 'x; prst_addr = 'x; prst_flags = 'x;
    for (int c = 0; c <= max_cyc; c++) begin
      @(posedge clk); #1;
      start     = (c == 0) || (c == restart_at);
      config_in = (c == restart_at) ? make_cfg(3, sy) : make_cfg(sx, sy);
      out_ready = !(stall_at >= 0 && c >= stall_at && c < stall_at + stall_len);
      rst       = (c == rst_at);
      @(negedge clk);
      if (rst_at >= 0 && c == rst_at + 1) begin
        prst_data  = out_data;
        prst_addr  = memZ_addr;
        prst_flags = {out_valid, out_last, busy_out, done_out};
      end
      if (out_valid) valid_seen = 1;
      if (busy_out) busy_seen = 1;
      if (out_valid && out_ready) begin
        got_q.push_back(out_data);
        got_last_q.push_back(out_last);
      end
      if (!out_ready) begin
        stall_data_q.push_back(out_data);
        stall_addr_q.push_back(memZ_addr);
        stall_valid_q.push_back(out_valid);
        stall_last_q.push_back(out_last);
      end
      if (done_out) begin
        if (done_cnt == 0) done_cyc = c;
        done_cnt++;
        if (rst_at < 0) break;
      end
    end
    start = 0; out_ready = 1; rst = 0;
  endtask

  task automatic test_reset;
    rst = 1; start = 0; out_ready = 1; config_in = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests_run++;
    if ({memZ_addr, out_data, out_valid, out_last, busy_out, done_out} !== '0) begin
      tests_failed++;
      $display("FAIL reset_values: addr=%0h data=%0h v=%b l=%b b=%b d=%b, required all 0",
               memZ_addr, out_data, out_valid, out_last, busy_out, done_out);
    end
    @(posedge clk); #1; rst = 0;
  endtask

  // Checks the full 10x5 stream: 28 words, last flag and done cycle.
  task automatic check_full_stream(input string name, input int exp_done);
    tests_run++;
    if (got_q.size() != 28) begin
      tests_failed++;
      $display("FAIL %s_count: got %0d words, required 28", name, got_q.size());
    end
    for (int n = 0; n < 28 && n < got_q.size(); n++) begin
      tests_run++;
      if (got_q[n] !== exp_word(n) || got_last_q[n] !== (n == 27)) begin
        tests_failed++;
        $display("FAIL %s_word%0d: data=%h last=%b, required data=%h last=%b",
                 name, n, got_q[n], got_last_q[n], exp_word(n), (n == 27));
      end
    end
    tests_run++;
    if (done_cyc != exp_done || done_cnt != 1) begin
      tests_failed++;
      $display("FAIL %s_done: cycle=%0d count=%0d, required cycle=%0d count=1",
               name, done_cyc, done_cnt, exp_done);
    end
  endtask

  task automatic test_basic;
    run_readout(10, 5, -1, 0, -1, -1, 80);
    check_full_stream("basic", 43);
  endtask

  task automatic test_backpressure;
    // Element 3 is in HI at cycle 12. Hold ready low for cycles 12..15.
    run_readout(10, 5, 12, 4, -1, -1, 80);
    check_full_stream("stall", 47);
    tests_run++;
    if (stall_data_q.size() != 4) begin
      tests_failed++;
      $display("FAIL stall_len: observed %0d stall cycles, required 4", stall_data_q.size());
    end
    for (int i = 0; i < stall_data_q.size(); i++) begin
      tests_run++;
      if (stall_data_q[i] !== 32'hA000_0003 || stall_addr_q[i] !== 6'd3 ||
          stall_valid_q[i] !== 1'b1 || stall_last_q[i] !== 1'b0) begin
        tests_failed++;
        $display("FAIL stall_hold%0d: data=%h addr=%0d v=%b l=%b, required A0000003 3 1 0",
                 i, stall_data_q[i], stall_addr_q[i], stall_valid_q[i], stall_last_q[i]);
      end
    end
  endtask

  task automatic test_empty;
    run_readout(0, 7, -1, 0, -1, -1, 10);
    tests_run++;
    if (got_q.size() != 0 || valid_seen || busy_seen || done_cyc != 1) begin
      tests_failed++;
      $display("FAIL empty: words=%0d valid_seen=%b busy_seen=%b done=%0d, required 0 0 0 1",
               got_q.size(), valid_seen, busy_seen, done_cyc);
    end
  endtask

  task automatic test_single;
    run_readout(1, 1, -1, 0, -1, -1, 20);
    tests_run++;
    if (got_q.size() != 2) begin
      tests_failed++;
      $display("FAIL single_count: got %0d words, required 2", got_q.size());
    end else begin
      tests_run++;
      if (got_q[0] !== 32'h0 || got_q[1] !== 32'hA000_0000 ||
          got_last_q[0] !== 1'b0 || got_last_q[1] !== 1'b1) begin
        tests_failed++;
        $display("FAIL single_words: %h/%b %h/%b, required 00000000/0 A0000000/1",
                 got_q[0], got_last_q[0], got_q[1], got_last_q[1]);
      end
    end
    tests_run++;
    if (done_cyc != 4) begin
      tests_failed++;
      $display("FAIL single_done: cycle=%0d, required 4", done_cyc);
    end
  endtask

  task automatic test_restart_ignored;
    run_readout(10, 5, -1, 0, 7, -1, 80);
    check_full_stream("restart", 43);
  endtask

  task automatic test_reset_mid;
    // Element 5 is in LO at cycle 17.
    run_readout(10, 5, -1, 0, -1, 17, 60);
    tests_run++;
    if (prst_data !== '0 || prst_addr !== '0 || prst_flags !== 4'b0000) begin
      tests_failed++;
      $display("FAIL rst_mid_outputs: data=%h addr=%0d {v,l,b,d}=%b, required all 0",
               prst_data, prst_addr, prst_flags);
    end
    tests_run++;
    if (done_cnt != 0) begin
      tests_failed++;
      $display("FAIL rst_mid_no_done: done pulses=%0d, required 0", done_cnt);
    end
    run_readout(10, 5, -1, 0, -1, -1, 80);
    check_full_stream("after_rst", 43);
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    for (int i = 0; i < 64; i++) mem[i] = {32'hA000_0000 + 32'(i), 32'(i)};
    test_reset();
    test_basic();
    test_backpressure();
    test_empty();
    test_single();
    test_restart_ignored();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
